// File: rtl/imem_loader.sv
// Boot-time loader: turns a framed byte stream (LEN, payload, CSUM) into 16-bit
// IMEM writes and keeps the CPU in reset until a frame has loaded cleanly.
module imem_loader #(
    parameter int im_size = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic                 imem_we,
    output logic [im_size-1:0]   imem_addr,
    output logic [15:0]          imem_wdata,
    output logic                 cpu_rst,
    output logic                 done,
    output logic                 error,
    output logic [im_size:0]     words_loaded
);

    localparam int CW = im_size + 1;

    localparam logic [2:0] S_LEN  = 3'd0;
    localparam logic [2:0] S_HI   = 3'd1;
    localparam logic [2:0] S_LO   = 3'd2;
    localparam logic [2:0] S_CSUM = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;
    localparam logic [2:0] S_ERR  = 3'd5;

    // Running checksum step: one byte folded into the accumulated XOR.
    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        csum_step = acc ^ b;
    endfunction

    logic [2:0]         state_r;
    logic [CW-1:0]      len_r;
    logic [CW-1:0]      count_r;
    logic [7:0]         csum_r;
    logic [7:0]         hi_r;
    logic               we_r;
    logic [im_size-1:0] addr_r;
    logic [15:0]        wdata_r;
    logic               cpu_rst_r;
    logic               done_r;
    logic               error_r;

    logic               rx_ready_s;
    logic               accept_s;
    logic [CW-1:0]      len_s;
    logic               last_word_s;

    // Byte acceptance: only while a frame is open and no restart is requested.
    always_comb begin
        rx_ready_s = 1'b0;
        case (state_r)
            S_LEN, S_HI, S_LO, S_CSUM: rx_ready_s = ~load;
            default:                   rx_ready_s = 1'b0;
        endcase
    end

    assign accept_s = rx_valid & rx_ready_s;

    // Word count decode: a zero LEN byte means a full IMEM image.
    always_comb begin
        len_s = {CW{1'b0}};
        if (rx_data == 8'h00) begin
            len_s = {1'b1, {im_size{1'b0}}};
        end else begin
            len_s = CW'(rx_data);
        end
    end

    assign last_word_s = ((count_r + CW'(1)) == len_r);

    // Frame FSM, word assembly, IMEM write port and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_LEN;
            len_r     <= {CW{1'b0}};
            count_r   <= {CW{1'b0}};
            csum_r    <= 8'h00;
            hi_r      <= 8'h00;
            we_r      <= 1'b0;
            addr_r    <= {im_size{1'b0}};
            wdata_r   <= 16'h0000;
            cpu_rst_r <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else if (load) begin
            // A write pulse already on the port this cycle completes; nothing new is issued.
            state_r   <= S_LEN;
            count_r   <= {CW{1'b0}};
            csum_r    <= 8'h00;
            we_r      <= 1'b0;
            cpu_rst_r <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            we_r <= 1'b0;
            if (accept_s) begin
                case (state_r)
                    S_LEN: begin
                        len_r   <= len_s;
                        csum_r  <= rx_data;
                        count_r <= {CW{1'b0}};
                        state_r <= S_HI;
                    end
                    S_HI: begin
                        hi_r    <= rx_data;
                        csum_r  <= csum_step(csum_r, rx_data);
                        state_r <= S_LO;
                    end
                    S_LO: begin
                        csum_r  <= csum_step(csum_r, rx_data);
                        we_r    <= 1'b1;
                        addr_r  <= count_r[im_size-1:0];
                        wdata_r <= {hi_r, rx_data};
                        count_r <= count_r + CW'(1);
                        state_r <= last_word_s ? S_CSUM : S_HI;
                    end
                    S_CSUM: begin
                        if (rx_data == csum_r) begin
                            done_r    <= 1'b1;
                            cpu_rst_r <= 1'b0;
                            state_r   <= S_DONE;
                        end else begin
                            error_r   <= 1'b1;
                            cpu_rst_r <= 1'b1;
                            state_r   <= S_ERR;
                        end
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

    assign rx_ready     = rx_ready_s;
    assign imem_we      = we_r;
    assign imem_addr    = addr_r;
    assign imem_wdata   = wdata_r;
    assign cpu_rst      = cpu_rst_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: good/bad/full-size frames, valid gaps,
// mid-frame restart via load and asynchronous reset.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        load;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int tests_run;
    int tests_failed;

    logic [7:0]  frame[$];
    logic [7:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];

    imem_loader #(.im_size(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .imem_we      (imem_we),
        .imem_addr    (imem_addr),
        .imem_wdata   (imem_wdata),
        .cpu_rst      (cpu_rst),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every IMEM write seen on the port (pre-edge values).
    always @(posedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_load();
        load = 1'b1;
        #1;
        check_val("rdy_in_load", {31'd0, rx_ready}, 32'd0);
        tick();
        load = 1'b0;
        check_val("wl_after_load", {23'd0, words_loaded}, 32'd0);
        check_val("cpurst_after_load", {31'd0, cpu_rst}, 32'd1);
        check_val("flags_after_load", {30'd0, done, error}, 32'd0);
    endtask

    // Send the queued frame; after each low byte confirm the write on the next cycle.
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame.size(); i++) begin
            if (gap != 0) tick();
            send(frame[i]);
            if (i >= 2 && i <= frame.size() - 2 && (i % 2) == 0) begin
                check_val("we_lat", {31'd0, imem_we}, 32'd1);
                check_val("we_addr", {24'd0, imem_addr}, (i / 2 - 1) % 256);
                check_val("we_data", {16'd0, imem_wdata}, {16'd0, frame[i-1], frame[i]});
                check_val("wl_inc", {23'd0, words_loaded}, i / 2);
            end
        end
    endtask

    task automatic check_writes(input string tag, input int n);
        int bad;
        bad = 0;
        check_val({tag, "_wr_count"}, wr_addr_q.size(), n);
        if (wr_addr_q.size() == n) begin
            for (int k = 0; k < n; k++) begin
                if (wr_addr_q[k] !== 8'(k)) bad++;
                if (wr_data_q[k] !== {frame[2*k+1], frame[2*k+2]}) bad++;
            end
        end
        check_val({tag, "_wr_content"}, bad, 0);
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic good_frame();
        frame = '{8'h03, 8'h10, 8'h00, 8'h12, 8'h41, 8'h11, 8'hB2, 8'hE3};
    endtask

    task automatic check_done(input string tag, input int n);
        check_val({tag, "_done"}, {31'd0, done}, 32'd1);
        check_val({tag, "_error"}, {31'd0, error}, 32'd0);
        check_val({tag, "_cpurst"}, {31'd0, cpu_rst}, 32'd0);
        check_val({tag, "_rdy"}, {31'd0, rx_ready}, 32'd0);
        check_val({tag, "_wl"}, {23'd0, words_loaded}, n);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        load     = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tick();
        check_val("rst_rdy", {31'd0, rx_ready}, 32'd1);
        check_val("rst_we", {31'd0, imem_we}, 32'd0);
        check_val("rst_addr", {24'd0, imem_addr}, 32'd0);
        check_val("rst_wdata", {16'd0, imem_wdata}, 32'd0);
        check_val("rst_cpurst", {31'd0, cpu_rst}, 32'd1);
        check_val("rst_flags", {30'd0, done, error}, 32'd0);
        check_val("rst_wl", {23'd0, words_loaded}, 32'd0);
        rst = 1'b0;
        tick();

        // Good frame, back-to-back bytes.
        clear_log();
        good_frame();
        send_frame(0);
        check_done("good", 3);
        tick();
        check_writes("good", 3);

        // Same frame with a wrong checksum.
        pulse_load();
        clear_log();
        good_frame();
        frame[7] = 8'hE2;
        send_frame(0);
        check_val("bad_error", {31'd0, error}, 32'd1);
        check_val("bad_done", {31'd0, done}, 32'd0);
        check_val("bad_cpurst", {31'd0, cpu_rst}, 32'd1);
        check_val("bad_rdy", {31'd0, rx_ready}, 32'd0);
        tick();
        check_writes("bad", 3);

        // LEN=0: full 256-word image, word k = {k, ~k}, checksum 00.
        pulse_load();
        clear_log();
        frame.delete();
        frame.push_back(8'h00);
        for (int k = 0; k < 256; k++) begin
            frame.push_back(8'(k));
            frame.push_back(~8'(k));
        end
        frame.push_back(8'h00);
        send_frame(0);
        check_done("full", 256);
        tick();
        check_writes("full", 256);

        // Good frame with rx_valid toggling.
        pulse_load();
        clear_log();
        good_frame();
        send_frame(1);
        check_done("gap", 3);
        tick();
        check_writes("gap", 3);

        // load after the 4th byte, with a byte offered during the load cycle.
        pulse_load();
        send(8'h03);
        send(8'h10);
        send(8'h00);
        send(8'h12);
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        pulse_load();
        rx_valid = 1'b0;
        tick();
        clear_log();
        good_frame();
        send_frame(0);
        check_done("reload", 3);
        tick();
        check_writes("reload", 3);

        // Asynchronous reset while in S_LO of word 1 with a byte pending.
        pulse_load();
        send(8'h03);
        send(8'h10);
        send(8'h00);
        send(8'h12);
        rx_data  = 8'h41;
        rx_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_val("arst_we", {31'd0, imem_we}, 32'd0);
        check_val("arst_cpurst", {31'd0, cpu_rst}, 32'd1);
        check_val("arst_wl", {23'd0, words_loaded}, 32'd0);
        check_val("arst_addr_data", {8'd0, imem_addr, imem_wdata}, 32'd0);
        check_val("arst_rdy", {31'd0, rx_ready}, 32'd1);
        tick();
        check_val("arst_we_held", {31'd0, imem_we}, 32'd0);
        rx_valid = 1'b0;
        rst = 1'b0;
        tick();
        clear_log();
        good_frame();
        send_frame(0);
        check_done("post_rst", 3);
        tick();
        check_writes("post_rst", 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
